// File: rtl/acc_pkg.sv
// Shared constants and FSM state type for the accelerator operand loader.
package acc_pkg;

    localparam int unsigned ACC_AW = 6;
    localparam int unsigned ACC_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4
    } acc_state_e;

endpackage

// File: rtl/acc_dma_addrgen.sv
// Base/index/size registers for the loader: wrapping word address and last-word detect.
module acc_dma_addrgen
    import acc_pkg::*;
#(
    parameter int unsigned AW = ACC_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] startaddr_i,
    input  logic [AW-1:0] datasize_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] base_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] size_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            idx_q  <= '0;
            size_q <= '0;
        end else if (load_i) begin
            base_q <= startaddr_i;
            size_q <= datasize_i;
            idx_q  <= '0;
        end else if (inc_i) begin
            idx_q  <= idx_q + AW'(1);
        end
    end

    // Sum truncates to AW bits, so the address wraps from the top word back to 0.
    assign addr_o = base_q + idx_q;
    assign last_o = ((idx_q + AW'(1)) == size_q);

endmodule

// File: rtl/acc_dma_loader.sv
// Accelerator operand loader: fetches datasize words from startaddr and streams them out.
// Optional running checksum enabled by defining ACC_DMA_LOADER_CHECKSUM_EN.
module acc_dma_loader
    import acc_pkg::*;
#(
    parameter int unsigned AW = ACC_AW,
    parameter int unsigned DW = ACC_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] startaddr,
    input  logic [AW-1:0] datasize,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic [DW-1:0] mem_rdata,
    output logic          acc_valid,
    output logic [DW-1:0] acc_data,
    input  logic          acc_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    acc_state_e    state_q, state_d;
    logic          load;
    logic          inc;
    logic          last;
    logic          abort;
    logic [DW-1:0] data_q;

    acc_dma_addrgen #(.AW(AW)) u_addrgen (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (load),
        .startaddr_i (startaddr),
        .datasize_i  (datasize),
        .inc_i       (inc),
        .addr_o      (mem_addr),
        .last_o      (last)
    );

    assign abort = flush && (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_d = (datasize == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
            ST_WAIT: state_d = ST_PUSH;
            ST_PUSH: begin
                if (acc_ready) begin
                    inc     = 1'b1;
                    state_d = last ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            inc     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_WAIT) && !flush) data_q <= mem_rdata;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign acc_valid = (state_q == ST_PUSH);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign acc_data  = data_q;

`ifdef ACC_DMA_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (abort || load) begin
            csum_q <= '0;
        end else if (inc) begin
            csum_q <= csum_q + data_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule
